// File: rtl/uart_calc_sequencer_pkg.sv
// Shared definitions for the UART calculator sequencer: FSM encoding,
// arithmetic opcodes, ASCII constants and small character/BCD helpers.
package uart_calc_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_A1   = 4'd1,
    ST_OPR  = 4'd2,
    ST_B0   = 4'd3,
    ST_B1   = 4'd4,
    ST_EXEC = 4'd5,
    ST_WAIT = 4'd6,
    ST_CONV = 4'd7,
    ST_SEND = 4'd8
  } state_t;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;
  localparam logic [7:0] ASCII_SLASH = 8'h2F;
  localparam logic [7:0] ASCII_EOL   = 8'h0A;
  localparam logic [7:0] ASCII_ERR   = 8'h45;

  // Longest response: '-', four digits, terminator.
  localparam int RESP_DEPTH = 6;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
  endfunction

  function automatic logic is_oper(input logic [7:0] c);
    return (c == ASCII_PLUS) || (c == ASCII_MINUS) ||
           (c == ASCII_STAR) || (c == ASCII_SLASH);
  endfunction

  function automatic logic [1:0] oper_code(input logic [7:0] c);
    logic [1:0] code;
    case (c)
      ASCII_PLUS:  code = OP_ADD;
      ASCII_MINUS: code = OP_SUB;
      ASCII_STAR:  code = OP_MUL;
      ASCII_SLASH: code = OP_DIV;
      default:     code = OP_ADD;
    endcase
    return code;
  endfunction

  // 10*d built from shifts so no multiplier is inferred; d <= 9 keeps it in 7 bits.
  function automatic logic [6:0] times_ten(input logic [6:0] d);
    return (d << 3'd3) + (d << 3'd1);
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      else                     r[4*i +: 4] = v[4*i +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_calc_sequencer_bin2bcd.sv
// Iterative double-dabble converter: 14-bit binary to four BCD digits.
// One load cycle on start, 14 shift-add-3 iterations, then a one-cycle done.
module uart_calc_sequencer_bin2bcd
  import uart_calc_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        done,
  output logic [15:0] bcd
);

  logic [13:0] shift_r;
  logic [15:0] bcd_r;
  logic [3:0]  cnt_r;
  logic        run_r;
  logic        done_r;
  logic [15:0] adj_s;

  assign adj_s = dabble_adjust(bcd_r);
  assign done  = done_r;
  assign bcd   = bcd_r;

  // Load on start, then shift one binary bit into the corrected BCD field per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_r <= 14'd0;
      bcd_r   <= 16'd0;
      cnt_r   <= 4'd0;
      run_r   <= 1'b0;
      done_r  <= 1'b0;
    end else if (start) begin
      shift_r <= bin;
      bcd_r   <= 16'd0;
      cnt_r   <= 4'd0;
      run_r   <= 1'b1;
      done_r  <= 1'b0;
    end else if (run_r) begin
      bcd_r   <= {adj_s[14:0], shift_r[13]};
      shift_r <= {shift_r[12:0], 1'b0};
      cnt_r   <= cnt_r + 4'd1;
      if (cnt_r == 4'd13) begin
        run_r  <= 1'b0;
        done_r <= 1'b1;
      end else begin
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_calc_sequencer.sv
// UART calculator sequencer: parses "DD op DD" ASCII frames, launches one
// operation on the shared arithmetic unit and streams the decimal result.
module uart_calc_sequencer
  import uart_calc_sequencer_pkg::*;
#(
  parameter logic [7:0] EOL      = ASCII_EOL,
  parameter logic [7:0] ERR_CHAR = ASCII_ERR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        op_start,
  output logic [1:0]  op_code,
  output logic [6:0]  op_a,
  output logic [6:0]  op_b,
  input  logic        op_done,
  input  logic [13:0] op_result,
  input  logic        op_err,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        overrun
);

  state_t      state_r, state_nxt_s;

  logic [6:0]  a_r, b0_r;
  logic [1:0]  opc_r;
  logic [6:0]  op_a_r, op_b_r;
  logic [1:0]  op_code_r;
  logic        neg_r;
  logic        op_start_r, busy_r, overrun_r;
  logic [7:0]  resp_r [RESP_DEPTH];
  logic [2:0]  tx_idx_r, tx_last_r;
  logic [7:0]  tx_data_r;
  logic        tx_valid_r;

  logic        rx_digit_s, rx_oper_s, class_ok_s;
  logic [6:0]  rx_val_s, b_full_s;
  logic        swap_s, drop_state_s, tx_fire_s, conv_start_s;
  logic        load_err_s, load_num_s;
  logic        bcd_done_s;
  logic [15:0] bcd_s;
  logic [7:0]  num_resp_s [RESP_DEPTH];
  logic [2:0]  num_cnt_s, num_last_s;
  logic        num_seen_s;

  assign rx_digit_s   = is_digit(rx_data);
  assign rx_oper_s    = is_oper(rx_data);
  assign class_ok_s   = (state_r == ST_OPR) ? rx_oper_s : rx_digit_s;
  assign rx_val_s     = {3'b000, rx_data[3:0]};
  assign b_full_s     = times_ten(b0_r) + rx_val_s;
  assign swap_s       = (opc_r == OP_SUB) && (a_r < b_full_s);
  assign drop_state_s = (state_r == ST_EXEC) || (state_r == ST_WAIT) ||
                        (state_r == ST_CONV) || (state_r == ST_SEND);
  assign tx_fire_s    = tx_valid_r && tx_ready;
  assign conv_start_s = (state_r == ST_WAIT) && op_done && !op_err;

  assign op_start = op_start_r;
  assign op_code  = op_code_r;
  assign op_a     = op_a_r;
  assign op_b     = op_b_r;
  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign busy     = busy_r;
  assign overrun  = overrun_r;

  uart_calc_sequencer_bin2bcd u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start_s),
    .bin   (op_result),
    .done  (bcd_done_s),
    .bcd   (bcd_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic plus the strobes that load the response buffer.
  always_comb begin
    state_nxt_s = state_r;
    load_err_s  = 1'b0;
    load_num_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid && rx_digit_s) state_nxt_s = ST_A1;
        else                        state_nxt_s = ST_IDLE;
      end
      ST_A1, ST_OPR, ST_B0, ST_B1: begin
        if (!rx_valid) begin
          state_nxt_s = state_r;
        end else if (!class_ok_s) begin
          state_nxt_s = ST_SEND;
          load_err_s  = 1'b1;
        end else if (state_r == ST_A1) begin
          state_nxt_s = ST_OPR;
        end else if (state_r == ST_OPR) begin
          state_nxt_s = ST_B0;
        end else if (state_r == ST_B0) begin
          state_nxt_s = ST_B1;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_EXEC: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (op_done && op_err) begin
          state_nxt_s = ST_SEND;
          load_err_s  = 1'b1;
        end else if (op_done) begin
          state_nxt_s = ST_CONV;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_CONV: begin
        if (bcd_done_s) begin
          state_nxt_s = ST_SEND;
          load_num_s  = 1'b1;
        end else begin
          state_nxt_s = ST_CONV;
        end
      end
      ST_SEND: begin
        if (tx_fire_s && (tx_idx_r == tx_last_r)) state_nxt_s = ST_IDLE;
        else                                      state_nxt_s = ST_SEND;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Builds the numeric response: optional '-', digits without leading zeros, EOL.
  always_comb begin
    for (int i = 0; i < RESP_DEPTH; i++) num_resp_s[i] = 8'h00;
    num_seen_s = 1'b0;
    if (neg_r) begin
      num_resp_s[0] = ASCII_MINUS;
      num_cnt_s     = 3'd1;
    end else begin
      num_cnt_s     = 3'd0;
    end
    for (int i = 3; i >= 0; i--) begin
      if ((bcd_s[4*i +: 4] != 4'd0) || num_seen_s || (i == 0)) begin
        num_resp_s[num_cnt_s] = {4'h3, bcd_s[4*i +: 4]};
        num_cnt_s             = num_cnt_s + 3'd1;
        num_seen_s            = 1'b1;
      end else begin
        num_seen_s            = num_seen_s;
      end
    end
    num_resp_s[num_cnt_s] = EOL;
    num_last_s            = num_cnt_s;
  end

  // Operand assembly; the subtraction swap keeps op_a >= op_b for the unit.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r       <= 7'd0;
      b0_r      <= 7'd0;
      opc_r     <= OP_ADD;
      op_a_r    <= 7'd0;
      op_b_r    <= 7'd0;
      op_code_r <= OP_ADD;
      neg_r     <= 1'b0;
    end else if (rx_valid && class_ok_s) begin
      case (state_r)
        ST_IDLE: a_r   <= rx_val_s;
        ST_A1:   a_r   <= times_ten(a_r) + rx_val_s;
        ST_OPR:  opc_r <= oper_code(rx_data);
        ST_B0:   b0_r  <= rx_val_s;
        ST_B1: begin
          op_code_r <= opc_r;
          neg_r     <= swap_s;
          op_a_r    <= swap_s ? b_full_s : a_r;
          op_b_r    <= swap_s ? a_r : b_full_s;
        end
        default: ;
      endcase
    end
  end

  // Registered status strobes: launch pulse, busy and dropped-byte indication.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_start_r <= 1'b0;
      busy_r     <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      op_start_r <= (state_nxt_s == ST_EXEC);
      busy_r     <= (state_nxt_s != ST_IDLE);
      overrun_r  <= rx_valid && drop_state_s;
    end
  end

  // Response buffer and transmit side: present bytes in order, hold under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RESP_DEPTH; i++) resp_r[i] <= 8'h00;
      tx_idx_r   <= 3'd0;
      tx_last_r  <= 3'd0;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
    end else if (load_err_s) begin
      resp_r[0]  <= ERR_CHAR;
      resp_r[1]  <= EOL;
      tx_idx_r   <= 3'd0;
      tx_last_r  <= 3'd1;
      tx_data_r  <= ERR_CHAR;
      tx_valid_r <= 1'b1;
    end else if (load_num_s) begin
      resp_r     <= num_resp_s;
      tx_idx_r   <= 3'd0;
      tx_last_r  <= num_last_s;
      tx_data_r  <= num_resp_s[0];
      tx_valid_r <= 1'b1;
    end else if (tx_fire_s) begin
      if (tx_idx_r == tx_last_r) begin
        tx_valid_r <= 1'b0;
      end else begin
        tx_idx_r   <= tx_idx_r + 3'd1;
        tx_data_r  <= resp_r[tx_idx_r + 3'd1];
      end
    end
  end

endmodule
